// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Multi-cycle unsigned multiply/divide sequencer that owns the
//                HI/LO special registers. MULTU uses a shift-add multiplier.
//                DIVU uses a restoring divider. Both take one step per cycle
//                and WIDTH steps in total. Divide-by-zero finishes straight
//                away with HI=a and LO=all ones. While an operation is in
//                flight, HI/LO accesses and new starts stall the CPU.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mf_req_i,
    input  logic             mf_hi_i,
    input  logic             mt_we_i,
    input  logic             mt_hi_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);

    // Step counter holds 0..WIDTH-1 plus one spare bit, so it never wraps.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    // Private working registers. They are never visible on rdata.
    // operand_q holds the multiplicand for MULTU and the divisor for DIVU.
    logic [WIDTH-1:0]   operand_q;
    logic [2*WIDTH-1:0] prod_q;      // upper half = partial sum, lower = multiplier
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;

    // Next-step datapath values
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_step;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_fits;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic               w_can_accept;

    // One shift-add multiply step and one restoring divide step, from current state
    always_comb begin
        // Multiply: conditionally add the multiplicand to the upper half, then
        // shift right with the carry entering the MSB.
        w_mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            w_mul_sum = w_mul_sum + {1'b0, operand_q};
        end
        w_prod_step = {w_mul_sum, prod_q[WIDTH-1:1]};

        // Divide: shift {rem,quo} left. The shifted remainder needs one
        // extra bit, because it can reach 2*divisor-1.
        w_rem_sh   = {rem_q, quo_q[WIDTH-1]};
        w_div_fits = (w_rem_sh >= {1'b0, operand_q});
        // When the divisor fits, the difference is below 2^WIDTH, so the
        // truncated subtraction is exact.
        w_rem_sub  = w_rem_sh[WIDTH-1:0] - operand_q;
        w_rem_step = w_div_fits ? w_rem_sub : w_rem_sh[WIDTH-1:0];
        w_quo_step = {quo_q[WIDTH-2:0], w_div_fits};
    end

    assign w_can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

    // Sequencer FSM: start acceptance, arithmetic steps, HI/LO updates and MTHI/MTLO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            operand_q <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        // A start accepted here wins over a simultaneous MTHI/MTLO
                        count_q <= '0;
                        if (!op_i) begin
                            operand_q <= a_i;
                            prod_q    <= {{WIDTH{1'b0}}, b_i};
                            state_q   <= S_MUL;
                            busy_q    <= 1'b1;
                        end else if (b_i != '0) begin
                            operand_q <= b_i;
                            rem_q     <= '0;
                            quo_q     <= a_i;
                            state_q   <= S_DIV;
                            busy_q    <= 1'b1;
                        end else begin
                            // Divide by zero: this result needs no iteration
                            hi_q    <= a_i;
                            lo_q    <= '1;
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        if (mt_we_i) begin
                            if (mt_hi_i) begin
                                hi_q <= wdata_i;
                            end else begin
                                lo_q <= wdata_i;
                            end
                        end
                    end
                end

                S_MUL: begin
                    prod_q  <= w_prod_step;
                    count_q <= count_q + c_CNT_ONE;
                    if (count_q == c_LAST_STEP) begin
                        hi_q    <= w_prod_step[2*WIDTH-1:WIDTH];
                        lo_q    <= w_prod_step[WIDTH-1:0];
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                S_DIV: begin
                    rem_q   <= w_rem_step;
                    quo_q   <= w_quo_step;
                    count_q <= count_q + c_CNT_ONE;
                    if (count_q == c_LAST_STEP) begin
                        hi_q    <= w_rem_step;
                        lo_q    <= w_quo_step;
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // rdata follows HI/LO directly, so DONE already shows the new result
    assign rdata_o = mf_hi_i ? hi_q : lo_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign stall_o = busy_q & (start_i | mf_req_i | mt_we_i);

    // w_can_accept documents the accepting states. The case labels above use the same states.
    logic w_unused;
    assign w_unused = w_can_accept;

endmodule
`default_nettype wire
